// File: rtl/memctrl_burst.sv
// rtl/memctrl_burst.sv - byte-serial RAM/IO controller: load/store plus cache-line refill bursts
// Define MEMCTRL_FLUSH_EN to let flush_in abort an in-flight fetch.
module memctrl_burst #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_word_valid,
  output logic [31:0]           fetch_word,
  output logic [IW-1:0]         fetch_word_idx,
  output logic                  fetch_done,
  input  logic                  ls_req,
  input  logic                  ls_store,
  input  logic [2:0]            ls_op,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata,
  input  logic                  flush_in,
  output logic                  busy,
  input  logic                  io_buffer_full,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  output logic [7:0]            mem_dout,
  input  logic [7:0]            mem_din
);

  localparam int CW = $clog2(LINE_WORDS) + 3;

  typedef enum logic [2:0] {IDLE, LOAD, STORE, FETCH, FINISH} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         len, cnt, pidx, ls_len;
  logic                  op_fetch, op_store, pend, late;
  logic [31:0]           wbuf, word_now;
  logic [7:0]            arr_byte;
  logic                  arr, issue, last_issue, flush_eff, accept_ls, accept_fetch;
  logic [ADDR_WIDTH-1:0] line_base;

  assign line_base  = fetch_addr & ~ADDR_WIDTH'(4 * LINE_WORDS - 1);
  assign last_issue = (cnt == len - 1'b1);
  // A read byte is either on mem_din now (pend) or was parked in wbuf while rdy_in was low (late).
  assign arr        = pend | late;
  assign arr_byte   = pend ? mem_din : wbuf[8*pidx[1:0] +: 8];

`ifdef MEMCTRL_FLUSH_EN
  assign flush_eff = rdy_in & flush_in & op_fetch & ((state == FETCH) | (state == FINISH));
`else
  assign flush_eff = 1'b0 & flush_in;
`endif

  always_comb begin
    case (ls_op[1:0])
      2'b00:   ls_len = CW'(1);
      2'b01:   ls_len = CW'(2);
      default: ls_len = CW'(4);
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    accept_ls        = 1'b0;
    accept_fetch     = 1'b0;
    issue            = 1'b0;
    word_now         = wbuf;
    word_now[8*pidx[1:0] +: 8] = arr_byte;
    if (rdy_in) begin
      case (state)
        IDLE: begin
          if (!io_buffer_full) begin
            if (ls_req) begin
              accept_ls = 1'b1;
              state_nx  = ls_store ? STORE : LOAD;
            end else if (fetch_req) begin
              accept_fetch = 1'b1;
              state_nx     = FETCH;
            end
          end
        end
        LOAD, STORE, FETCH: begin
          if (flush_eff) begin
            state_nx = IDLE;
          end else if (!io_buffer_full) begin
            issue = 1'b1;
            if (last_issue) state_nx = FINISH;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    busy             = (state != IDLE);
    mem_wr           = issue && (state == STORE);
    mem_dout         = mem_wr ? ls_wdata[8*cnt[1:0] +: 8] : 8'h00;
    ls_done          = rdy_in && (state == FINISH) && !op_fetch;
    fetch_word_valid = rdy_in && op_fetch && arr && (pidx[1:0] == 2'd3) && !flush_eff;
    fetch_done       = fetch_word_valid && (state == FINISH);
    fetch_word       = fetch_word_valid ? word_now : 32'h0;
    fetch_word_idx   = fetch_word_valid ? IW'(pidx >> 2) : '0;
    ls_rdata         = 32'h0;
    if (ls_done && !op_store) begin
      case (ls_op[1:0])
        2'b00:   ls_rdata = {{24{~ls_op[2] & word_now[7]}}, word_now[7:0]};
        2'b01:   ls_rdata = {{16{~ls_op[2] & word_now[15]}}, word_now[15:0]};
        default: ls_rdata = word_now;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_a    <= '0;
      len      <= '0;
      cnt      <= '0;
      pidx     <= '0;
      op_fetch <= 1'b0;
      op_store <= 1'b0;
      pend     <= 1'b0;
      late     <= 1'b0;
      wbuf     <= 32'h0;
    end else begin
      // The RAM answers regardless of rdy_in, so the in-flight byte is always captured.
      if (pend) wbuf[8*pidx[1:0] +: 8] <= mem_din;
      if (rdy_in) begin
        late <= 1'b0;
        pend <= issue && (state != STORE);
        if (accept_ls || accept_fetch) begin
          mem_a    <= accept_ls ? ls_addr : line_base;
          len      <= accept_ls ? ls_len : CW'(4 * LINE_WORDS);
          cnt      <= '0;
          op_fetch <= accept_fetch;
          op_store <= accept_ls && ls_store;
        end else if (issue) begin
          pidx <= cnt;
          cnt  <= cnt + 1'b1;
          if (!last_issue) mem_a <= mem_a + 1'b1;
        end
      end else if (pend) begin
        late <= 1'b1;
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memctrl_burst.sv
// tb/tb_memctrl_burst.sv - randomized self-checking bench for memctrl_burst
module tb_memctrl_burst;
  localparam int AW = 16;
  localparam int LW = 4;
  localparam int NB = 4 * LW;
`ifdef MEMCTRL_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, fetch_req, ls_req, ls_store, flush_in, io_buffer_full;
  logic [AW-1:0] fetch_addr, ls_addr, mem_a;
  logic [2:0]    ls_op;
  logic [31:0]   ls_wdata, fetch_word, ls_rdata;
  logic          fetch_word_valid, fetch_done, ls_done, busy, mem_wr;
  logic [1:0]    fetch_word_idx;
  logic [7:0]    mem_dout, mem_din;
  logic [7:0]    ram [0:(1<<AW)-1];
  int            vectors = 0;
  int            miscompares = 0;

  memctrl_burst #(.ADDR_WIDTH(AW), .LINE_WORDS(LW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_word_valid(fetch_word_valid),
    .fetch_word(fetch_word), .fetch_word_idx(fetch_word_idx), .fetch_done(fetch_done),
    .ls_req(ls_req), .ls_store(ls_store), .ls_op(ls_op), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata), .flush_in(flush_in),
    .busy(busy), .io_buffer_full(io_buffer_full), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    mem_din <= ram[mem_a];
    if (mem_wr) ram[mem_a] <= mem_dout;
  end

  // Transaction model: each unstalled, ready cycle issues the next byte; an issued byte
  // arrives at the next ready cycle; completion is the arrival of the final byte.
  task automatic run_txn(input bit is_fetch, input bit is_store, input logic [AW-1:0] addr,
                         input logic [2:0] op, input logic [31:0] wdata, input bit rnd_stall,
                         input bit rnd_rdy, input logic [63:0] stall_mask, input int flush_cyc,
                         input int rst_cyc, input bit keep_fetch);
    int n, issued, pending, post;
    logic [AW-1:0] base;
    logic [7:0] img [0:NB-1];
    logic [31:0] w, exp_load, exp_fw;
    bit arrive, iss, flushnow, exp_fv, exp_fd, exp_ld, done, aborted;
    base = is_fetch ? (addr & ~AW'(NB - 1)) : addr;
    n = is_fetch ? NB : ((op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4);
    for (int k = 0; k < n; k++) img[k] = ram[AW'(base + k)];
    w = 32'h0;
    for (int k = 0; k < n && k < 4; k++) w[8*k +: 8] = img[k];
    case (op[1:0])
      2'b00:   exp_load = op[2] ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
      2'b01:   exp_load = op[2] ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: exp_load = w;
    endcase
    ls_req = !is_fetch; fetch_req = is_fetch | keep_fetch; ls_store = is_store;
    ls_op = op; ls_addr = addr; ls_wdata = wdata;
    if (is_fetch) fetch_addr = addr;
    issued = 0; pending = -1; post = 0; done = 0; aborted = 0;
    for (int c = 0; c < 400; c++) begin
      if (aborted) begin ls_req = 1'b0; fetch_req = 1'b0; end
      if (c == 0) begin
        rdy_in = 1'b1; io_buffer_full = 1'b0;
      end else begin
        rdy_in = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        io_buffer_full = (c < 64 && stall_mask[c]) || (rnd_stall && $urandom_range(0, 2) == 0);
      end
      if (c == flush_cyc) rdy_in = 1'b1;
      rst_in = (c == rst_cyc);
      flush_in = (c == flush_cyc);
      @(negedge clk_in);
      if (aborted) begin
        vectors++;
        if (busy !== 1'b0 || fetch_word_valid !== 1'b0 || fetch_done !== 1'b0 || ls_done !== 1'b0 || mem_wr !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_idle c=%0d busy=%b fwv=%b fdone=%b lsdone=%b wr=%b required all 0",
                   c, busy, fetch_word_valid, fetch_done, ls_done, mem_wr);
        end
      end else if (c == 0) begin
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL accept_busy got %b required 0", busy); end
      end else if (c != rst_cyc) begin
        flushnow = FLUSH_ON && (c == flush_cyc);
        arrive = rdy_in && pending >= 0 && !flushnow;
        iss = rdy_in && !io_buffer_full && issued < n && !flushnow;
        exp_fv = is_fetch && arrive && (pending % 4 == 3);
        exp_fd = is_fetch && arrive && (pending == n - 1);
        exp_ld = !is_fetch && arrive && (pending == n - 1);
        vectors++;
        if (busy !== 1'b1 || mem_wr !== (is_store && iss) || fetch_word_valid !== exp_fv ||
            fetch_done !== exp_fd || ls_done !== exp_ld) begin
          miscompares++;
          $display("FAIL strobes c=%0d got busy=%b wr=%b fwv=%b fdone=%b lsdone=%b required 1 %b %b %b %b",
                   c, busy, mem_wr, fetch_word_valid, fetch_done, ls_done, is_store && iss, exp_fv, exp_fd, exp_ld);
        end
        if (iss) begin
          vectors++;
          if (mem_a !== AW'(base + issued) || (is_store && mem_dout !== wdata[8*issued +: 8])) begin
            miscompares++;
            $display("FAIL issue c=%0d got a=%h dout=%h required a=%h dout=%h", c, mem_a, mem_dout,
                     AW'(base + issued), wdata[8*issued +: 8]);
          end
        end
        if (exp_fv) begin
          exp_fw = {img[pending], img[pending-1], img[pending-2], img[pending-3]};
          vectors++;
          if (fetch_word !== exp_fw || fetch_word_idx !== 2'(pending / 4)) begin
            miscompares++;
            $display("FAIL fetch_word c=%0d got %h idx %0d required %h idx %0d", c, fetch_word,
                     fetch_word_idx, exp_fw, pending / 4);
          end
        end
        if (exp_ld && !is_store) begin
          vectors++;
          if (ls_rdata !== exp_load) begin
            miscompares++;
            $display("FAIL ls_rdata c=%0d got %h required %h", c, ls_rdata, exp_load);
          end
        end
        if (arrive) begin
          if (pending == n - 1) done = 1'b1;
          pending = -1;
        end
        if (iss) begin pending = issued; issued++; end
      end
      @(posedge clk_in); #1;
      if (c == rst_cyc || (FLUSH_ON && c == flush_cyc)) aborted = 1'b1;
      if (aborted) post++;
      if (done || post > 4) break;
    end
    if (!done && !aborted) begin
      miscompares++;
      $display("FAIL timeout txn at %h got no completion required completion", addr);
    end
    ls_req = 1'b0; fetch_req = keep_fetch; rst_in = 1'b0; flush_in = 1'b0;
    rdy_in = 1'b1; io_buffer_full = 1'b0;
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    vectors++;
    if (mem_a !== 0 || mem_wr !== 0 || mem_dout !== 0 || busy !== 0 || ls_done !== 0 || ls_rdata !== 0 ||
        fetch_word_valid !== 0 || fetch_done !== 0 || fetch_word !== 0 || fetch_word_idx !== 0) begin
      miscompares++;
      $display("FAIL reset got a=%h wr=%b dout=%h busy=%b lsd=%b rd=%h fwv=%b fd=%b fw=%h idx=%0d required all 0",
               mem_a, mem_wr, mem_dout, busy, ls_done, ls_rdata, fetch_word_valid, fetch_done, fetch_word, fetch_word_idx);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
  endtask

  task automatic test_load_sign;
    ram[16'h0100] = 8'h80;
    run_txn(0, 0, 16'h0100, 3'b000, 32'h0, 0, 0, 64'h0, -1, -1, 0);
    run_txn(0, 0, 16'h0100, 3'b100, 32'h0, 0, 0, 64'h0, -1, -1, 0);
    @(negedge clk_in);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL load_idle busy=%b required 0", busy); end
    @(posedge clk_in); #1;
  endtask

  task automatic test_store_unaligned;
    logic [31:0] d;
    d = 32'hDEADBEEF;
    run_txn(0, 1, 16'h2001, 3'b010, d, 0, 0, 64'h0, -1, -1, 0);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (ram[16'h2001 + k] !== d[8*k +: 8]) begin
        miscompares++;
        $display("FAIL store_ram byte %0d got %h required %h", k, ram[16'h2001 + k], d[8*k +: 8]);
      end
    end
  endtask

  task automatic test_fetch;
    run_txn(1, 0, 16'h1004, 3'b000, 32'h0, 0, 0, 64'h0, -1, -1, 0);
  endtask

  task automatic test_priority;
    fetch_addr = 16'h3040;
    run_txn(0, 0, 16'h0500, 3'b010, 32'h0, 0, 0, 64'h0, -1, -1, 1);
    run_txn(1, 0, 16'h3040, 3'b000, 32'h0, 0, 0, 64'h0, -1, -1, 0);
  endtask

  task automatic test_stall;
    ram[16'h0030] = 8'h34; ram[16'h0031] = 8'hB2;
    run_txn(0, 0, 16'h0030, 3'b001, 32'h0, 0, 0, 64'h4, -1, -1, 0);
  endtask

  task automatic test_wrap;
    run_txn(0, 0, 16'hFFFE, 3'b010, 32'h0, 0, 0, 64'h0, -1, -1, 0);
    run_txn(0, 1, 16'hFFFF, 3'b001, 32'h1234A5C3, 0, 0, 64'h0, -1, -1, 0);
    run_txn(0, 0, 16'hFFFF, 3'b101, 32'h0, 0, 0, 64'h0, -1, -1, 0);
  endtask

  task automatic test_reset_mid_fetch;
    run_txn(1, 0, 16'h4000, 3'b000, 32'h0, 0, 0, 64'h0, -1, 2, 0);
  endtask

  task automatic test_flush;
    run_txn(1, 0, 16'h5010, 3'b000, 32'h0, 0, 0, 64'h0, 7, -1, 0);
    run_txn(0, 0, 16'h5011, 3'b100, 32'h0, 0, 0, 64'h0, 1, -1, 0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [AW-1:0] a;
      kind = $urandom_range(0, 9);
      a = (i % 8 == 0) ? AW'(16'hFFFD + $urandom_range(0, 2)) : AW'($urandom);
      run_txn(kind < 3, kind >= 3 && kind < 6, a, 3'($urandom), $urandom, 1, 1, 64'h0, -1, -1, 0);
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; fetch_req = 1'b0; ls_req = 1'b0; ls_store = 1'b0; ls_op = 3'b0;
    ls_addr = '0; ls_wdata = 32'h0; flush_in = 1'b0; io_buffer_full = 1'b0; fetch_addr = '0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'($urandom);
    test_reset;
    test_load_sign;
    test_store_unaligned;
    test_fetch;
    test_priority;
    test_stall;
    test_wrap;
    test_reset_mid_fetch;
    test_flush;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
